// File: rtl/beam_summer.sv
`default_nettype none
// ============================================================================
// Module   : beam_summer
// Purpose  : Four-channel AXI-Stream beam combiner. Joins four sample streams
//            (channels 00, 01, 20, 21), adds them per sample through a 2-stage
//            skid-free pipeline and emits one combined stream.
//            Stage 1 : pairwise sums a = s00+s01, b = s20+s21 (W+1 bits).
//            Stage 2 : a+b (W+2 bits) reduced back to W bits.
// Config   : BEAM_SUMMER_SAT_EN defined   -> reduction saturates to signed W.
//            BEAM_SUMMER_SAT_EN undefined -> reduction is floor(sum/4), the
//                                            four-channel average.
// Ports    : clock, reset (sync, active high)
//            sXX_axis_{tdata,tvalid,tlast} in / sXX_axis_tready out, XX in
//            {00,01,20,21}; m_axis_{tdata,tvalid,tlast} out / m_axis_tready
//            in; frame_count (completed output frames, wraps); tlast_err
//            (sticky: accepted beat whose four tlast bits disagreed).
// Revision : 1.0 - initial release
// ============================================================================
module beam_summer #(
    parameter int SDATA_WIDTH  = 128,
    parameter int SAMPLE_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [SDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                   s00_axis_tvalid,
    input  logic                   s00_axis_tlast,
    output logic                   s00_axis_tready,
    input  logic [SDATA_WIDTH-1:0] s01_axis_tdata,
    input  logic                   s01_axis_tvalid,
    input  logic                   s01_axis_tlast,
    output logic                   s01_axis_tready,
    input  logic [SDATA_WIDTH-1:0] s20_axis_tdata,
    input  logic                   s20_axis_tvalid,
    input  logic                   s20_axis_tlast,
    output logic                   s20_axis_tready,
    input  logic [SDATA_WIDTH-1:0] s21_axis_tdata,
    input  logic                   s21_axis_tvalid,
    input  logic                   s21_axis_tlast,
    output logic                   s21_axis_tready,
    output logic [SDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [15:0]            frame_count,
    output logic                   tlast_err
);

    localparam int c_N_SAMPLES = SDATA_WIDTH / SAMPLE_WIDTH;
    localparam int c_AW        = SAMPLE_WIDTH + 1;   // pairwise sum width
    localparam int c_SW        = SAMPLE_WIDTH + 2;   // four-way sum width

    logic                          r_v1;
    logic                          r_v2;
    logic [c_N_SAMPLES*c_AW-1:0]   r_a;
    logic [c_N_SAMPLES*c_AW-1:0]   r_b;
    logic                          r_tlast1;
    logic [SDATA_WIDTH-1:0]        r_data2;
    logic                          r_tlast2;
    logic [15:0]                   r_frame_count;
    logic                          r_tlast_err;

    logic                          w_all_valid;
    logic                          w_s1_ready;
    logic                          w_s2_ready;
    logic                          w_accept;
    logic [3:0]                    w_lasts;
    logic                          w_lane_mismatch;
    logic [c_N_SAMPLES*c_AW-1:0]   w_a_all;
    logic [c_N_SAMPLES*c_AW-1:0]   w_b_all;
    logic [SDATA_WIDTH-1:0]        w_red_all;

    // Join: nothing is consumed unless every channel offers a beat, and never
    // while reset is held.
    assign w_all_valid = s00_axis_tvalid & s01_axis_tvalid
                       & s20_axis_tvalid & s21_axis_tvalid;
    assign w_s2_ready  = ~r_v2 | m_axis_tready;
    assign w_s1_ready  = ~r_v1 | w_s2_ready;
    assign w_accept    = w_all_valid & w_s1_ready & ~reset;

    assign s00_axis_tready = w_accept;
    assign s01_axis_tready = w_accept;
    assign s20_axis_tready = w_accept;
    assign s21_axis_tready = w_accept;

    assign w_lasts         = {s00_axis_tlast, s01_axis_tlast, s20_axis_tlast, s21_axis_tlast};
    assign w_lane_mismatch = ~((&w_lasts) | ~(|w_lasts));

    for (genvar k = 0; k < c_N_SAMPLES; k++) begin : g_sample
        logic [SAMPLE_WIDTH-1:0] w_x00, w_x01, w_x20, w_x21;
        logic [c_AW-1:0]         w_ak, w_bk;

        assign w_x00 = s00_axis_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        assign w_x01 = s01_axis_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        assign w_x20 = s20_axis_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        assign w_x21 = s21_axis_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];

        // Sign-extend by one bit before adding so the pairwise sum never wraps.
        assign w_a_all[k*c_AW +: c_AW] = {w_x00[SAMPLE_WIDTH-1], w_x00} + {w_x01[SAMPLE_WIDTH-1], w_x01};
        assign w_b_all[k*c_AW +: c_AW] = {w_x20[SAMPLE_WIDTH-1], w_x20} + {w_x21[SAMPLE_WIDTH-1], w_x21};

        assign w_ak = r_a[k*c_AW +: c_AW];
        assign w_bk = r_b[k*c_AW +: c_AW];

`ifdef BEAM_SUMMER_SAT_EN
        logic [c_SW-1:0] w_sum;
        logic            w_ovf;

        assign w_sum = {w_ak[c_AW-1], w_ak} + {w_bk[c_AW-1], w_bk};
        // The sum fits in SAMPLE_WIDTH bits only when every bit from the
        // target sign position upward is a copy of the sign.
        assign w_ovf = ~((&w_sum[c_SW-1:SAMPLE_WIDTH-1]) | ~(|w_sum[c_SW-1:SAMPLE_WIDTH-1]));
        assign w_red_all[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
            !w_ovf        ? w_sum[SAMPLE_WIDTH-1:0] :
            w_sum[c_SW-1] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}} :
                            {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
`else
        // Arithmetic shift of the full-width signed sum gives floor(sum/4).
        assign w_red_all[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
            SAMPLE_WIDTH'(($signed({w_ak[c_AW-1], w_ak}) + $signed({w_bk[c_AW-1], w_bk})) >>> 2);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v1          <= 1'b0;
            r_v2          <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_tlast1      <= 1'b0;
            r_data2       <= '0;
            r_tlast2      <= 1'b0;
            r_frame_count <= 16'd0;
            r_tlast_err   <= 1'b0;
        end else begin
            // A stage that is free to move either refills or empties.
            if (w_s1_ready) begin
                r_v1 <= w_accept;
                if (w_accept) begin
                    r_a      <= w_a_all;
                    r_b      <= w_b_all;
                    r_tlast1 <= s00_axis_tlast;
                end
            end
            if (w_s2_ready) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_data2  <= w_red_all;
                    r_tlast2 <= r_tlast1;
                end
            end
            if (r_v2 && m_axis_tready && r_tlast2) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_accept && w_lane_mismatch) begin
                r_tlast_err <= 1'b1;
            end
        end
    end

    assign m_axis_tdata  = r_data2;
    assign m_axis_tvalid = r_v2;
    assign m_axis_tlast  = r_tlast2;
    assign frame_count   = r_frame_count;
    assign tlast_err     = r_tlast_err;

endmodule
`default_nettype wire

// File: tb/tb_beam_summer.sv
`default_nettype none
// ============================================================================
// Module   : tb_beam_summer
// Purpose  : Self-checking bench for beam_summer. Expected values follow the
//            build: BEAM_SUMMER_SAT_EN selects the saturating column.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beam_summer;
    localparam int W = 128;
    localparam int S = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] d00, d01, d20, d21;
    logic         v00, v01, v20, v21;
    logic         l00, l01, l20, l21;
    logic         r00, r01, r20, r21;
    logic [W-1:0] m_tdata;
    logic         m_tvalid, m_tready, m_tlast;
    logic [15:0]  fc;
    logic         err;

    beam_summer #(.SDATA_WIDTH(W), .SAMPLE_WIDTH(S)) dut (
        .clock(clock), .reset(reset),
        .s00_axis_tdata(d00), .s00_axis_tvalid(v00), .s00_axis_tlast(l00), .s00_axis_tready(r00),
        .s01_axis_tdata(d01), .s01_axis_tvalid(v01), .s01_axis_tlast(l01), .s01_axis_tready(r01),
        .s20_axis_tdata(d20), .s20_axis_tvalid(v20), .s20_axis_tlast(l20), .s20_axis_tready(r20),
        .s21_axis_tdata(d21), .s21_axis_tvalid(v21), .s21_axis_tlast(l21), .s21_axis_tready(r21),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .frame_count(fc), .tlast_err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] c0, c1, c2, c3;
        logic [7:0] e_avg, e_sat;
    } vec_t;

    vec_t tv[11];
    int   checks   = 0;
    int   failures = 0;

    // Output monitor: a transfer is recorded at the negedge preceding the
    // posedge on which it completes.
    logic [W-1:0] got_d[256];
    logic         got_l[256];
    int           n_got = 0;

    always @(negedge clock) begin
        if (m_tvalid && m_tready && !reset && n_got < 256) begin
            got_d[n_got] = m_tdata;
            got_l[n_got] = m_tlast;
            n_got = n_got + 1;
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [7:0] v);
        return {16{v}};
    endfunction

    function automatic logic [7:0] pick(input vec_t t);
`ifdef BEAM_SUMMER_SAT_EN
        return t.e_sat;
`else
        return t.e_avg;
`endif
    endfunction

    // Expected output sample when all four channels carry the same value v.
    function automatic logic [7:0] exp_u(input logic [7:0] v);
        int s;
        s = 4 * int'($signed(v));
`ifdef BEAM_SUMMER_SAT_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`else
        s = s / 4;
`endif
        return 8'(s);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic [3:0] last, output int cyc);
        bit ok;
        ok  = 0;
        cyc = 0;
        d00 = d; d01 = d; d20 = d; d21 = d;
        {l00, l01, l20, l21} = last;
        {v00, v01, v20, v21} = 4'hF;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            cyc = cyc + 1;
            if (r00) begin
                ok = 1;
                tick();
                break;
            end
            tick();
        end
        {v00, v01, v20, v21} = 4'h0;
        {l00, l01, l20, l21} = 4'h0;
        if (!ok) chk("send_timeout", W'(0), W'(1));
    endtask

    initial begin
        int           n0, cyc, total;
        logic [W-1:0] held, lane_in, lane_exp;

        //            c0     c1     c2     c3     avg    sat
        tv[0]  = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h40};
        tv[1]  = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        tv[2]  = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        tv[3]  = '{8'h7F, 8'h7F, 8'h01, 8'h00, 8'h3F, 8'h7F};
        tv[4]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv[5]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
        tv[6]  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        tv[7]  = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        tv[8]  = '{8'h40, 8'h40, 8'hC0, 8'h00, 8'h10, 8'h40};
        tv[9]  = '{8'h80, 8'h80, 8'h7F, 8'h00, 8'hDF, 8'h80};
        tv[10] = '{8'h60, 8'h60, 8'h00, 8'h00, 8'h30, 8'h7F};

        // Reset state, with all channels offering data during reset.
        d00 = rep(8'h10); d01 = d00; d20 = d00; d21 = d00;
        {v00, v01, v20, v21} = 4'hF;
        {l00, l01, l20, l21} = 4'h0;
        m_tready = 1'b1;
        repeat (2) tick();
        chk("rst_s00_tready", W'(r00), W'(0));
        chk("rst_s21_tready", W'(r21), W'(0));
        chk("rst_m_tvalid",   W'(m_tvalid), W'(0));
        chk("rst_m_tlast",    W'(m_tlast), W'(0));
        chk("rst_m_tdata",    m_tdata, W'(0));
        chk("rst_frame_count", W'(fc), W'(0));
        chk("rst_tlast_err",  W'(err), W'(0));
        {v00, v01, v20, v21} = 4'h0;
        reset = 1'b0;
        tick();

        // Table vectors: single beat each, latency two cycles.
        for (int i = 0; i < 11; i++) begin
            d00 = rep(tv[i].c0); d01 = rep(tv[i].c1);
            d20 = rep(tv[i].c2); d21 = rep(tv[i].c3);
            {v00, v01, v20, v21} = 4'hF;
            @(negedge clock);
            chk($sformatf("vec%0d_tready", i), W'({r00, r01, r20, r21}), W'(4'hF));
            tick();
            {v00, v01, v20, v21} = 4'h0;
            chk($sformatf("vec%0d_early_valid", i), W'(m_tvalid), W'(0));
            tick();
            chk($sformatf("vec%0d_valid", i), W'(m_tvalid), W'(1));
            chk($sformatf("vec%0d_data", i), m_tdata, rep(pick(tv[i])));
            tick();
            chk($sformatf("vec%0d_empty", i), W'(m_tvalid), W'(0));
        end

        // Lane placement: sample k carries value k on every channel.
        for (int k = 0; k < 16; k++) begin
            lane_in[k*8 +: 8]  = 8'(k);
            lane_exp[k*8 +: 8] = exp_u(8'(k));
        end
        send_beat(lane_in, 4'h0, cyc);
        tick();
        chk("lane_valid", W'(m_tvalid), W'(1));
        chk("lane_data", m_tdata, lane_exp);
        tick();

        // Join: channel 20 withheld for three cycles.
        d00 = rep(8'h05); d01 = d00; d20 = d00; d21 = d00;
        {v00, v01, v20, v21} = 4'b1101;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("join_no_tready", W'(r00), W'(0));
            chk("join_no_output", W'(m_tvalid), W'(0));
            tick();
        end
        v20 = 1'b1;
        @(negedge clock);
        chk("join_tready_same_cycle", W'(r00), W'(1));
        tick();
        {v00, v01, v20, v21} = 4'h0;
        tick();
        chk("join_valid", W'(m_tvalid), W'(1));
        chk("join_data", m_tdata, rep(exp_u(8'h05)));
        tick();

        // Eight-beat stream with a four-cycle downstream stall.
        n0 = n_got;
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(rep(8'(3 + 2*i)), 4'h0, cyc);
            end
            begin
                repeat (3) @(posedge clock);
                #1;
                m_tready = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clock);
                    if (c == 0) begin
                        held = m_tdata;
                    end else begin
                        chk("stall_data_stable", m_tdata, held);
                        chk("stall_tready_low", W'(r00), W'(0));
                        chk("stall_valid_high", W'(m_tvalid), W'(1));
                    end
                    tick();
                end
                m_tready = 1'b1;
            end
        join
        repeat (6) tick();
        chk("stream_count", W'(n_got - n0), W'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stream_beat%0d", i), got_d[n0 + i], rep(exp_u(8'(3 + 2*i))));
        end

        // Full throughput without backpressure: one accept per clock.
        total = 0;
        for (int i = 0; i < 6; i++) begin
            send_beat(rep(8'(20 + i)), 4'h0, cyc);
            total = total + cyc;
        end
        chk("throughput_cycles", W'(total), W'(6));
        repeat (4) tick();

        // Well-formed frame.
        chk("frame_count_before", W'(fc), W'(0));
        n0 = n_got;
        for (int i = 0; i < 4; i++) send_beat(rep(8'(i + 1)), (i == 3) ? 4'hF : 4'h0, cyc);
        repeat (4) tick();
        chk("frame1_count", W'(fc), W'(1));
        chk("frame1_err", W'(err), W'(0));
        chk("frame1_last_beat4", W'(got_l[n0 + 3]), W'(1));
        chk("frame1_last_beat3", W'(got_l[n0 + 2]), W'(0));

        // Misaligned frame: channel 21 ends one beat early.
        n0 = n_got;
        send_beat(rep(8'h01), 4'h0, cyc);
        send_beat(rep(8'h02), 4'h0, cyc);
        send_beat(rep(8'h03), 4'b0001, cyc);
        send_beat(rep(8'h04), 4'b1110, cyc);
        repeat (4) tick();
        chk("frame2_err", W'(err), W'(1));
        chk("frame2_count", W'(fc), W'(2));
        chk("frame2_last_beat3", W'(got_l[n0 + 2]), W'(0));
        chk("frame2_last_beat4", W'(got_l[n0 + 3]), W'(1));
        repeat (5) tick();
        chk("err_sticky", W'(err), W'(1));

        // Reset with two beats in flight.
        m_tready = 1'b0;
        send_beat(rep(8'h07), 4'h0, cyc);
        send_beat(rep(8'h08), 4'h0, cyc);
        chk("inflight_valid", W'(m_tvalid), W'(1));
        n0 = n_got;
        reset = 1'b1;
        d00 = rep(8'h09); d01 = d00; d20 = d00; d21 = d00;
        {v00, v01, v20, v21} = 4'hF;
        @(negedge clock);
        chk("reset_no_accept", W'(r00), W'(0));
        tick();
        chk("reset_valid_cleared", W'(m_tvalid), W'(0));
        chk("reset_frame_count", W'(fc), W'(0));
        chk("reset_err_cleared", W'(err), W'(0));
        chk("reset_data_cleared", m_tdata, W'(0));
        reset = 1'b0;
        {v00, v01, v20, v21} = 4'h0;
        m_tready = 1'b1;
        repeat (5) tick();
        chk("no_stale_output", W'(n_got - n0), W'(0));
        chk("post_reset_idle", W'(m_tvalid), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/beam_summer.md
BEAM_SUMMER -- requirements
Module: beam_summer

Interface
REQ-001 Parameter SDATA_WIDTH, default 128, input/output beat width in bits.
REQ-002 Parameter SAMPLE_WIDTH, default 8, signed sample width; samples per beat N = SDATA_WIDTH/SAMPLE_WIDTH (16).
REQ-003 clock  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sXX_axis_tdata  input  SDATA_WIDTH  channel beat, XX in {00,01,20,21}; sample k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-006 sXX_axis_tvalid  input  1  channel beat valid, one per channel.
REQ-007 sXX_axis_tlast  input  1  channel end-of-frame, one per channel.
REQ-008 sXX_axis_tready  output  1  channel accept, one per channel; all four driven identically.
REQ-009 m_axis_tdata  output  SDATA_WIDTH  combined beam beat, same sample packing.
REQ-010 m_axis_tvalid  output  1  output beat valid.
REQ-011 m_axis_tready  input  1  downstream accept.
REQ-012 m_axis_tlast  output  1  end-of-frame of combined stream.
REQ-013 frame_count  output  16  completed output frames.
REQ-014 tlast_err  output  1  sticky lane-misalignment flag.

Function
REQ-015 Join: input transfer occurs only in a cycle where all four sXX_axis_tvalid are high and sXX_axis_tready is high; partial valid is never consumed.
REQ-016 sXX_axis_tready = (all four tvalid) AND stage-1 ready; stage-1 ready = !v1 OR stage-2 ready; stage-2 ready = !v2 OR m_axis_tready.
REQ-017 Stage 1 registers, per sample k, the pairwise sign-extended sums a=s00+s01 and b=s20+s21 (SAMPLE_WIDTH+1 bits), plus tlast of channel 00.
REQ-018 Stage 2 registers, per sample k, a+b (SAMPLE_WIDTH+2 bits) reduced to SAMPLE_WIDTH per REQ-030/031, plus tlast.
REQ-019 Latency: beat accepted in cycle T appears on m_axis_* in cycle T+2 when no backpressure; throughput one beat per clock.
REQ-020 m_axis_tvalid = v2; m_axis_tdata/tlast hold stable while tvalid high and tready low.
REQ-021 With m_axis_tready low and both stages full, sXX_axis_tready is low; no beat is dropped or duplicated.
REQ-022 A stage empties (valid cleared) when it passes its content on and receives none.
REQ-023 frame_count increments by 1 on each output transfer with m_axis_tlast high; wraps 0xFFFF -> 0x0000.
REQ-024 tlast_err sets on any accepted input beat whose four tlast bits are not all equal; remains set until reset.
REQ-025 Output tlast follows channel 00 tlast regardless of tlast_err.
REQ-026 Simultaneous stage-2 output and stage-1 refill in the same cycle: both occur; pipeline stays full.

Reset
REQ-027 While reset high: v1, v2, m_axis_tvalid, m_axis_tlast, sXX_axis_tready, tlast_err low; m_axis_tdata 0; frame_count 0.
REQ-028 Reset asserted mid-frame discards all in-flight beats; first cycle after deassertion behaves as empty pipeline.
REQ-029 No input transfer is accepted in a cycle where reset is high.

Configuration
REQ-030 With macro BEAM_SUMMER_SAT_EN defined: each 10-bit sum saturated to signed 8-bit range (>127 -> 127, < -128 -> -128).
REQ-031 Without BEAM_SUMMER_SAT_EN: each 10-bit sum arithmetic-shifted right by 2 (floor), i.e. four-channel average; no saturation logic present.

Verification
REQ-032 All four channels sample value 0x10, m_axis_tready=1 -> output samples 0x40 (SAT_EN) / 0x10 (no SAT_EN) at T+2.
REQ-033 All channels 0x7F -> 0x7F both builds; all 0x80 -> 0x80 both builds; channels 0x7F,0x7F,0x01,0x00 -> 0x7F (SAT_EN) / 0x3F (no SAT_EN).
REQ-034 Channel 20 tvalid low for 3 cycles, others high -> no tready, no output; on tvalid rise beat accepted same cycle.
REQ-035 Stream 8 beats, m_axis_tready low for 4 cycles mid-stream -> 8 in-order output beats, tdata stable during stall, tready low with both stages full.
REQ-036 Frame of 4 beats with tlast on beat 4 all channels -> frame_count 1, tlast_err 0; repeat with channel 21 tlast on beat 3 -> tlast_err 1 until reset.
REQ-037 Reset asserted with 2 beats in flight -> m_axis_tvalid 0 next cycle, frame_count 0, no stale beat emitted after release.
